id_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the ID-stage decode flags. Consumes the per-instruction

---
 rtl/id_hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_sb_shift.sv | 64 ++++++
 rtl/id_hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard.
//   FWD_RF          forwarding select value meaning "read the register file"
//   RDY_ALU         scoreboard position at whose end an ALU result is ready
//   MD_LAT_DEFAULT  default mult/div occupancy in cycles
//   sbEntryT        one scoreboard slot: {v, addr, rdy}
// The entry struct uses fixed field widths so one typedef serves every
// parameterisation. Register addresses up to SB_ADDR_W bits and ready
// positions up to 2**SB_RDY_W-1 are supported.
package id_hazard_scoreboard_pkg;

  localparam int FWD_RF         = 0;
  localparam int RDY_ALU        = 1;
  localparam int MD_LAT_DEFAULT = 32;

  localparam int SB_ADDR_W = 8;
  localparam int SB_RDY_W  = 4;

  typedef struct packed {
    logic                 v;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_RDY_W-1:0]  rdy;
  } sbEntryT;

endpackage

// File: rtl/hazard_sb_shift.sv
// DEPTH-entry shift scoreboard of in-flight register writes plus a
// youngest-match priority encoder for one operand address.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears every slot)
//   insValid     write a valid entry into position 1 this cycle (else bubble)
//   insAddr      destination address of the inserted entry
//   insRdy       position at whose end the inserted result becomes available
//   lookupAddr   operand address to search for (address 0 never matches)
//   hit          a valid entry matches lookupAddr
//   hitPos       position (1..DEPTH) of the youngest matching entry
//   hitRdy       ready position stored in that entry
module hazard_sb_shift
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                insValid,
  input  logic [REG_AW-1:0]   insAddr,
  input  logic [SB_RDY_W-1:0] insRdy,
  input  logic [REG_AW-1:0]   lookupAddr,
  output logic                hit,
  output logic [SEL_W-1:0]    hitPos,
  output logic [SB_RDY_W-1:0] hitRdy
);

  // sb[1] holds the instruction now in EX, sb[DEPTH] the one in WB.
  sbEntryT sb [1:DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      sb[1].v    <= insValid;
      sb[1].addr <= SB_ADDR_W'(insAddr);
      sb[1].rdy  <= insRdy;
      for (int k = 2; k <= DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit    = 1'b0;
    hitPos = '0;
    hitRdy = '0;
    if (lookupAddr != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (sb[k].v && (sb[k].addr == SB_ADDR_W'(lookupAddr))) begin
          hit    = 1'b1;
          hitPos = SEL_W'(k);
          hitRdy = sb[k].rdy;
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight GPR writes, produces the ID
// stall, per-operand forwarding selects and a mult/div busy interlock.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID holds a valid instruction
//   id_rs, id_rt             operand addresses
//   id_rs_use, id_rt_use     operand is read
//   id_early                 used operands are needed in ID (branch compare)
//   id_wr_en, id_wr_addr     instruction writes id_wr_addr
//   id_is_load               the write comes from a load
//   id_md_start, id_md_read  mult/div issue, mfhi/mflo
//   flush                    kill the ID instruction this cycle
//   stall                    hold PC and IF/ID, bubble into EX
//   fwd_rs_sel, fwd_rt_sel   0 = register file, k = latch after position k
//   md_busy                  mult/div occupied
//   stall_cycles             saturating count of stalled cycles
// Flow control: id_valid qualifies every ID input. When stall=1 the ID
// instruction is not consumed and stays presented; it issues (scoreboard
// insert, mult/div start) only in a cycle with id_valid=1, stall=0, flush=0.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT     = MD_LAT_DEFAULT,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_early,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_md_start,
  input  logic              id_md_read,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy,
  output logic [31:0]       stall_cycles
);

  localparam int MD_CNT_W = $clog2(MD_LAT + 1);

  logic                insValid;
  logic [SB_RDY_W-1:0] insRdy;
  logic                rsHit, rtHit;
  logic [SEL_W-1:0]    rsPos, rtPos;
  logic [SB_RDY_W-1:0] rsRdy, rtRdy;
  logic                rsStall, rtStall, mdStall, stallInt;
  logic [MD_CNT_W-1:0] mdCnt;
  logic [31:0]         stallCnt;

  // Operand at position k is not yet obtainable. EX use needs the value at
  // the end of the producer's ready position; an ID (early) use needs it one
  // position sooner.
  function automatic logic opStall(input logic used, input logic hitIn,
                                   input logic early,
                                   input logic [SEL_W-1:0] pos,
                                   input logic [SB_RDY_W-1:0] rdy);
    int k;
    int r;
    k = int'(pos);
    r = int'(rdy);
    if (!used || !hitIn) return 1'b0;
    return early ? (k <= r) : (k < r);
  endfunction

  // Forwarding source once the operand is obtainable. An EX use at DEPTH
  // reads the register file, which is written in WB; an early use reads the
  // latch one position younger because it samples a cycle before EX.
  function automatic logic [SEL_W-1:0] opSel(input logic used, input logic hitIn,
                                             input logic early,
                                             input logic [SEL_W-1:0] pos);
    int k;
    k = int'(pos);
    if (!used || !hitIn) return SEL_W'(FWD_RF);
    if (early) return SEL_W'(k - 1);
    return (k == DEPTH) ? SEL_W'(FWD_RF) : pos;
  endfunction

  hazard_sb_shift #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_sb_rs (
    .clk       (clk),
    .rst       (rst),
    .insValid  (insValid),
    .insAddr   (id_wr_addr),
    .insRdy    (insRdy),
    .lookupAddr(id_rs),
    .hit       (rsHit),
    .hitPos    (rsPos),
    .hitRdy    (rsRdy)
  );

  hazard_sb_shift #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_sb_rt (
    .clk       (clk),
    .rst       (rst),
    .insValid  (insValid),
    .insAddr   (id_wr_addr),
    .insRdy    (insRdy),
    .lookupAddr(id_rt),
    .hit       (rtHit),
    .hitPos    (rtPos),
    .hitRdy    (rtRdy)
  );

  always_comb begin
    insRdy   = id_is_load ? SB_RDY_W'(LOAD_STAGE) : SB_RDY_W'(RDY_ALU);
    rsStall  = opStall(id_rs_use, rsHit, id_early, rsPos, rsRdy);
    rtStall  = opStall(id_rt_use, rtHit, id_early, rtPos, rtRdy);
    mdStall  = (id_md_read | id_md_start) & (mdCnt != '0);
    stallInt = !rst && id_valid && !flush && (rsStall || rtStall || mdStall);
    insValid = id_valid && id_wr_en && (id_wr_addr != '0) && !stallInt && !flush;

    stall      = stallInt;
    fwd_rs_sel = SEL_W'(FWD_RF);
    fwd_rt_sel = SEL_W'(FWD_RF);
    if (!rst && !flush) begin
      if (!rsStall) fwd_rs_sel = opSel(id_rs_use, rsHit, id_early, rsPos);
      if (!rtStall) fwd_rt_sel = opSel(id_rt_use, rtHit, id_early, rtPos);
    end
    md_busy      = !rst && (mdCnt != '0);
    stall_cycles = stallCnt;
  end

  // mult/div occupancy and stall performance counter. A reset abandons any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdCnt    <= '0;
      stallCnt <= '0;
    end else begin
      if (id_md_start && id_valid && !stallInt && !flush) begin
        mdCnt <= MD_CNT_W'(MD_LAT);
      end else if (mdCnt != '0) begin
        mdCnt <= mdCnt - MD_CNT_W'(1);
      end
      if (stallInt && (stallCnt != 32'hFFFF_FFFF)) begin
        stallCnt <= stallCnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

  localparam int AW = 5;
  localparam int SW = 2;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          id_valid, id_rs_use, id_rt_use, id_early, id_wr_en, id_is_load;
  logic          id_md_start, id_md_read, flush;
  logic [AW-1:0] id_rs, id_rt, id_wr_addr;
  logic          stall, md_busy;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0]   stall_cycles;

  id_hazard_scoreboard #(.REG_AW(AW), .DEPTH(3), .LOAD_STAGE(2), .MD_LAT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_use   (id_rs_use),
    .id_rt_use   (id_rt_use),
    .id_early    (id_early),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .id_md_start (id_md_start),
    .id_md_read  (id_md_read),
    .flush       (flush),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .md_busy     (md_busy),
    .stall_cycles(stall_cycles)
  );

  // scoreboard: {stall, fwd_rs_sel, fwd_rt_sel, md_busy}
  logic [5:0]  exp_q[$];
  logic [31:0] exp_stalls;
  int          n_vec;
  int          n_err;

  // driver: present one ID cycle after the active edge, queue its expected
  // outputs, then wait for the sampling point on the falling edge
  task automatic apply(input logic r, input logic v, input int rs, input int rt,
                       input logic rsu, input logic rtu, input logic early,
                       input logic wr, input int wa, input logic ld,
                       input logic mds, input logic mdr, input logic fl,
                       input logic est, input int ers, input int ert, input logic eb);
    @(posedge clk);
    #1;
    rst         = r;
    id_valid    = v;
    id_rs       = AW'(rs);
    id_rt       = AW'(rt);
    id_rs_use   = rsu;
    id_rt_use   = rtu;
    id_early    = early;
    id_wr_en    = wr;
    id_wr_addr  = AW'(wa);
    id_is_load  = ld;
    id_md_start = mds;
    id_md_read  = mdr;
    flush       = fl;
    exp_q.push_back({est, SW'(ers), SW'(ert), eb});
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [5:0] got, e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) apply(1, 1, 3, 3, 1, 1, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0);
      else       idle();
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== 32'd0) begin
        n_err++;
        $display("FAIL reset[%0d] stall_cycles got %0d expected 0", i, stall_cycles);
      end
    end
    exp_stalls = 32'd0;
  endtask

  task automatic test_ex_fwd();
    logic [5:0] got, e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        3:       apply(0, 1, 1, 2, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        4:       apply(0, 1, 3, 5, 1, 1, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0);
        5:       apply(0, 1, 4, 3, 1, 1, 0, 1, 6, 0, 0, 0, 0, 0, 1, 2, 0);
        6:       apply(0, 1, 3, 4, 1, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 2, 0);
        default: idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL ex_fwd[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL ex_fwd[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  task automatic test_load_use();
    logic [5:0] got, e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        3:       apply(0, 1, 29, 0, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        4:       apply(0, 1, 3, 3, 1, 1, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0);
        5:       apply(0, 1, 3, 3, 1, 1, 0, 1, 4, 0, 0, 0, 0, 0, 2, 2, 0);
        default: idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL load_use[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL load_use[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  task automatic test_early();
    logic [5:0] got, e;
    for (int i = 0; i < 11; i++) begin
      case (i)
        3:       apply(0, 1, 1, 2, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        4:       apply(0, 1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        5:       apply(0, 1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6:       apply(0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        7, 8:    apply(0, 1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        9:       apply(0, 1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        default: idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL early[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL early[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  task automatic test_zero_reg();
    logic [5:0] got, e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       apply(0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        1:       apply(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        2:       apply(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        3:       apply(0, 1, 0, 0, 1, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        default: idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL zero_reg[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL zero_reg[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  task automatic test_md();
    logic [5:0] got, e;
    for (int i = 0; i < 10; i++) begin
      case (i)
        2:          apply(0, 1, 8, 9, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        3, 4, 5, 6: apply(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 1, 0, 0, 1);
        7:          apply(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
        8:          apply(0, 1, 10, 0, 1, 1, 0, 1, 11, 0, 0, 0, 0, 0, 1, 0, 0);
        default:    idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL md[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL md[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  task automatic test_flush_reset();
    logic [5:0] got, e;
    for (int i = 0; i < 12; i++) begin
      case (i)
        2:       apply(0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        3:       apply(0, 1, 3, 3, 1, 1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        4:       apply(0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        5:       apply(0, 1, 3, 5, 1, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
        6:       apply(0, 1, 3, 5, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 2, 0, 0);
        7:       apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        8:       apply(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 1, 0, 0, 1);
        9:       apply(1, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
        11:      apply(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
        default: idle();
      endcase
      got = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL flush_reset[%0d] outputs got %b expected %b", i, got, e);
      end
      n_vec++;
      if (stall_cycles !== exp_stalls) begin
        n_err++;
        $display("FAIL flush_reset[%0d] stall_cycles got %0d expected %0d", i, stall_cycles, exp_stalls);
      end
      if (rst) exp_stalls = 32'd0; else if (e[5]) exp_stalls++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_rs_use   = 1'b0;
    id_rt_use   = 1'b0;
    id_early    = 1'b0;
    id_wr_en    = 1'b0;
    id_wr_addr  = '0;
    id_is_load  = 1'b0;
    id_md_start = 1'b0;
    id_md_read  = 1'b0;
    flush       = 1'b0;
    exp_stalls  = 32'd0;
    n_vec       = 0;
    n_err       = 0;

    test_reset();
    test_ex_fwd();
    test_load_use();
    test_early();
    test_zero_reg();
    test_md();
    test_flush_reset();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover expectations got %0d expected 0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
